// File: rtl/systolic_operand_loader_if.sv
// Byte stream into the systolic operand loader: valid/ready handshake plus one operand byte.
interface systolic_operand_loader_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/systolic_operand_loader.sv
// Serial operand loader for the 2x2 systolic convolution array: assembles image and filter
// buses from a byte stream and sequences the array reset/compute window.
// Optional build macro SYSTOLIC_LOADER_FILTER_REUSE_EN: filter loaded only once after reset.
module systolic_operand_loader #(
    parameter int DATA_W         = 8,
    parameter int IMG_N          = 16,
    parameter int FLT_N          = 9,
    parameter int RST_HOLD       = 2,
    parameter int COMPUTE_CYCLES = 50
) (
    input  logic                      clk,
    input  logic                      rst,
    systolic_operand_loader_if.slave  stream,
    output logic [IMG_N*DATA_W-1:0]   img_flat,
    output logic [FLT_N*DATA_W-1:0]   flt_flat,
    output logic                      array_rst,
    output logic                      busy,
    output logic                      frame_done,
    output logic [7:0]                frame_count
);
    localparam int BYTE_MAX = (IMG_N > FLT_N) ? IMG_N : FLT_N;
    localparam int TIME_MAX = (COMPUTE_CYCLES > RST_HOLD) ? COMPUTE_CYCLES : RST_HOLD;
    localparam int CW       = $clog2(BYTE_MAX + 1);
    localparam int TW       = $clog2(TIME_MAX + 1);

    typedef enum logic [1:0] {
        LOAD_IMG,
        LOAD_FLT,
        HOLD,
        COMPUTE
    } state_t;

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] byte_cnt;
    logic [TW-1:0] timer;
    logic          ready_q;
    logic          accept;
    logic          skip_flt;
    logic          load_next;
    logic          busy_next;

    assign stream.in_ready = ready_q;
    assign accept          = stream.in_valid & ready_q;

`ifdef SYSTOLIC_LOADER_FILTER_REUSE_EN
    logic flt_loaded;

    always_ff @(posedge clk) begin
        if (rst) begin
            flt_loaded <= 1'b0;
        end else if (state == LOAD_FLT && state_next == HOLD) begin
            flt_loaded <= 1'b1;
        end
    end

    assign skip_flt = flt_loaded;
`else
    assign skip_flt = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            LOAD_IMG: begin
                if (accept && byte_cnt == CW'(IMG_N - 1)) begin
                    state_next = skip_flt ? HOLD : LOAD_FLT;
                end
            end
            LOAD_FLT: begin
                if (accept && byte_cnt == CW'(FLT_N - 1)) begin
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (timer == TW'(RST_HOLD - 1)) begin
                    state_next = COMPUTE;
                end
            end
            COMPUTE: begin
                if (timer == TW'(COMPUTE_CYCLES - 1)) begin
                    state_next = LOAD_IMG;
                end
            end
            default: state_next = LOAD_IMG;
        endcase
        load_next = (state_next == LOAD_IMG) || (state_next == LOAD_FLT);
        busy_next = (state_next == HOLD) || (state == HOLD) || (state == COMPUTE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= LOAD_IMG;
            byte_cnt    <= '0;
            timer       <= '0;
            ready_q     <= 1'b0;
            img_flat    <= '0;
            flt_flat    <= '0;
            array_rst   <= 1'b1;
            busy        <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= 8'd0;
        end else begin
            state   <= state_next;
            ready_q <= load_next;

            if (state_next != state) begin
                byte_cnt <= '0;
            end else if (accept) begin
                byte_cnt <= byte_cnt + 1'b1;
            end

            if (state_next != state) begin
                timer <= '0;
            end else if (state == HOLD || state == COMPUTE) begin
                timer <= timer + 1'b1;
            end else begin
                timer <= '0;
            end

            // Byte k of each phase lands in slot k, slot 0 being the most significant byte.
            for (int k = 0; k < IMG_N; k++) begin
                if (accept && state == LOAD_IMG && byte_cnt == CW'(k)) begin
                    img_flat[(IMG_N-1-k)*DATA_W +: DATA_W] <= stream.in_data;
                end
            end
            for (int k = 0; k < FLT_N; k++) begin
                if (accept && state == LOAD_FLT && byte_cnt == CW'(k)) begin
                    flt_flat[(FLT_N-1-k)*DATA_W +: DATA_W] <= stream.in_data;
                end
            end

            // The array sees its reset one cycle behind the state, so it releases
            // RST_HOLD+1 cycles after the final byte and re-asserts as the window closes.
            array_rst  <= (state != COMPUTE);
            busy       <= busy_next;
            frame_done <= (state != COMPUTE) && !array_rst;
            if ((state != COMPUTE) && !array_rst) begin
                frame_count <= frame_count + 8'd1;
            end
        end
    end
endmodule

// File: tb/tb_systolic_operand_loader.sv
// Scoreboard bench for systolic_operand_loader: frames are modelled when queued and
// compared against the buses and frame counter when frame_done fires.
module tb_systolic_operand_loader;
    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] img_flat;
    logic [71:0]  flt_flat;
    logic         array_rst;
    logic         busy;
    logic         frame_done;
    logic [7:0]   frame_count;

    always #5 clk = ~clk;

    systolic_operand_loader_if #(.DATA_W(8)) bus ();

    systolic_operand_loader dut (
        .clk        (clk),
        .rst        (rst),
        .stream     (bus),
        .img_flat   (img_flat),
        .flt_flat   (flt_flat),
        .array_rst  (array_rst),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_count(frame_count)
    );

    typedef struct {
        logic [127:0] img;
        logic [71:0]  flt;
        logic [7:0]   cnt;
    } exp_t;

    int checks = 0;
    int passes = 0;

    logic [7:0]   img_a [16] = '{8'd9, 8'd8, 8'd2, 8'd6, 8'd0, 8'd4, 8'd1, 8'd6,
                                 8'd4, 8'd10, 8'd1, 8'd1, 8'd2, 8'd2, 8'd9, 8'd9};
    logic [7:0]   flt_a [9]  = '{8'd3, 8'd2, 8'd0, 8'd2, 8'd0, 8'd1, 8'd3, 8'd1, 8'd1};

    logic [127:0] img_model;
    logic [71:0]  flt_model;
    logic [7:0]   cnt_model;
    bit           flt_loaded_model;
    logic [7:0]   tx_q [$];
    exp_t         sb [$];

    function automatic logic [7:0] img_byte(input int sel, input int i);
        if (sel == 0) return img_a[i];
        return 8'((i * 37 + 11) % 256);
    endfunction

    function automatic logic [7:0] flt_byte(input int sel, input int i);
        if (sel == 0) return flt_a[i];
        return 8'((i * 53 + 200) % 256);
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        img_model        = '0;
        flt_model        = '0;
        cnt_model        = 8'd0;
        flt_loaded_model = 1'b0;
        tx_q.delete();
        sb.delete();
    endtask

    // Queue one frame's bytes and, if it is meant to complete, its expected result.
    task automatic queue_frame(input int sel, input bit expect_done);
        exp_t e;
        bit   send_flt;
        send_flt = 1'b1;
`ifdef SYSTOLIC_LOADER_FILTER_REUSE_EN
        send_flt = !flt_loaded_model;
`endif
        for (int i = 0; i < 16; i++) begin
            tx_q.push_back(img_byte(sel, i));
            img_model = {img_model[119:0], img_byte(sel, i)};
        end
        if (send_flt) begin
            for (int i = 0; i < 9; i++) begin
                tx_q.push_back(flt_byte(sel, i));
                flt_model = {flt_model[63:0], flt_byte(sel, i)};
            end
            flt_loaded_model = 1'b1;
        end
        if (expect_done) begin
            cnt_model = cnt_model + 8'd1;
            e.img = img_model;
            e.flt = flt_model;
            e.cnt = cnt_model;
            sb.push_back(e);
        end
    endtask

    // Present up to n queued bytes; a byte leaves the queue only on an accepting edge.
    task automatic drive_stream(input int n, input bit throttle, output int cycles,
                                output bit first_acc, output bit bad_seen);
        int sent;
        bit rdy;
        sent      = 0;
        cycles    = 0;
        first_acc = 1'b0;
        bad_seen  = 1'b0;
        while (sent < n && tx_q.size() > 0 && cycles < 200) begin
            bus.in_valid = throttle ? ((cycles % 2) == 0) : 1'b1;
            bus.in_data  = tx_q[0];
            rdy          = bus.in_ready;
            if (array_rst !== 1'b1) bad_seen = 1'b1;
            if (cycles > 0 && frame_done === 1'b1) bad_seen = 1'b1;
            cyc();
            if (bus.in_valid && rdy) begin
                if (cycles == 0) first_acc = 1'b1;
                void'(tx_q.pop_front());
                sent++;
            end
            cycles++;
        end
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
    endtask

    // Follow the array window to the frame_done cycle and pop the matching expectation.
    task automatic finish_window(output int fall, output int low, output int early_done,
                                 output bit have, output exp_t e);
        fall       = 0;
        low        = 0;
        early_done = 0;
        have       = 1'b0;
        e.img      = '0;
        e.flt      = '0;
        e.cnt      = 8'd0;
        while (array_rst === 1'b1 && fall < 20) begin
            cyc();
            fall++;
            if (frame_done === 1'b1) early_done++;
        end
        while (array_rst === 1'b0 && low < 200) begin
            if (frame_done === 1'b1) early_done++;
            cyc();
            low++;
        end
        if (frame_done === 1'b1 && sb.size() > 0) begin
            e    = sb.pop_front();
            have = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        model_reset();
        cyc();
        cyc();
        checks++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready: got %b want 0", bus.in_ready); else passes++;
        checks++; if (array_rst !== 1'b1) $display("FAIL reset_array_rst: got %b want 1", array_rst); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else passes++;
        checks++; if (frame_done !== 1'b0) $display("FAIL reset_frame_done: got %b want 0", frame_done); else passes++;
        checks++; if (frame_count !== 8'd0) $display("FAIL reset_frame_count: got %0d want 0", frame_count); else passes++;
        checks++; if (img_flat !== 128'd0 || flt_flat !== 72'd0) $display("FAIL reset_buses: got img=%h flt=%h want 0", img_flat, flt_flat); else passes++;
        rst = 1'b0;
        cyc();
        checks++; if (bus.in_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", bus.in_ready); else passes++;
    endtask

    task automatic test_single_frame();
        int cycles, n, fall, low, early, dones;
        bit first_acc, bad, have;
        exp_t e;
        queue_frame(0, 1'b1);
        n = tx_q.size();
        drive_stream(n, 1'b0, cycles, first_acc, bad);
        checks++; if (cycles !== n) $display("FAIL single_load_cycles: got %0d want %0d", cycles, n); else passes++;
`ifndef SYSTOLIC_LOADER_FILTER_REUSE_EN
        checks++; if (img_flat !== 128'h0908_0206_0004_0106_040A_0101_0202_0909) $display("FAIL single_img_literal: got %h", img_flat); else passes++;
        checks++; if (flt_flat !== 72'h030200020001030101) $display("FAIL single_flt_literal: got %h want 030200020001030101", flt_flat); else passes++;
`endif
        checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b0) $display("FAIL single_hold_entry: got busy=%b ready=%b want 1 0", busy, bus.in_ready); else passes++;
        finish_window(fall, low, early, have, e);
        checks++; if (fall !== 3) $display("FAIL single_rst_fall_latency: got %0d want 3", fall); else passes++;
        checks++; if (low !== 50) $display("FAIL single_compute_len: got %0d want 50", low); else passes++;
        checks++; if (early !== 0 || have !== 1'b1) $display("FAIL single_done_timing: got early=%0d have=%b want 0 1", early, have); else passes++;
        checks++; if (img_flat !== e.img || flt_flat !== e.flt) $display("FAIL single_sb_buses: got img=%h flt=%h want img=%h flt=%h", img_flat, flt_flat, e.img, e.flt); else passes++;
        checks++; if (frame_count !== e.cnt) $display("FAIL single_frame_count: got %0d want %0d", frame_count, e.cnt); else passes++;
        checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL single_done_flags: got busy=%b ready=%b want 0 1", busy, bus.in_ready); else passes++;
        dones = 0;
        for (int i = 0; i < 5; i++) begin
            cyc();
            if (frame_done === 1'b1) dones++;
        end
        checks++; if (dones !== 0) $display("FAIL single_done_once: got %0d extra pulses want 0", dones); else passes++;
    endtask

    task automatic test_throttled();
        int cycles, n, fall, low, early;
        bit first_acc, bad, have;
        exp_t e;
        queue_frame(0, 1'b1);
        n = tx_q.size();
        drive_stream(n, 1'b1, cycles, first_acc, bad);
        // The 1,0 pattern ends on its last accepted byte, so the idle half of the last pair is not spent.
        checks++; if (cycles !== 2 * n - 1) $display("FAIL throttle_load_cycles: got %0d want %0d", cycles, 2 * n - 1); else passes++;
        finish_window(fall, low, early, have, e);
        checks++; if (have !== 1'b1 || img_flat !== e.img || flt_flat !== e.flt) $display("FAIL throttle_sb_buses: got have=%b img=%h flt=%h want img=%h flt=%h", have, img_flat, flt_flat, e.img, e.flt); else passes++;
        checks++; if (frame_count !== e.cnt) $display("FAIL throttle_frame_count: got %0d want %0d", frame_count, e.cnt); else passes++;
    endtask

    task automatic test_back_to_back();
        int cycles, n, fall, low, early;
        bit first_acc, bad, have;
        exp_t e;
        checks++; if (frame_done !== 1'b1) $display("FAIL b2b_start_in_done: got %b want 1", frame_done); else passes++;
        queue_frame(1, 1'b1);
        n = tx_q.size();
        drive_stream(n, 1'b0, cycles, first_acc, bad);
        checks++; if (first_acc !== 1'b1) $display("FAIL b2b_first_accept: got %b want 1", first_acc); else passes++;
        checks++; if (bad !== 1'b0) $display("FAIL b2b_rst_low_in_load: got %b want 0", bad); else passes++;
        finish_window(fall, low, early, have, e);
        checks++; if (have !== 1'b1 || img_flat !== e.img || flt_flat !== e.flt) $display("FAIL b2b_sb_buses: got have=%b img=%h flt=%h want img=%h flt=%h", have, img_flat, flt_flat, e.img, e.flt); else passes++;
        checks++; if (frame_count !== e.cnt) $display("FAIL b2b_frame_count: got %0d want %0d", frame_count, e.cnt); else passes++;
    endtask

    task automatic test_reset_mid_load();
        int cycles, n, fall, low, early;
        bit first_acc, bad, have;
        exp_t e;
        queue_frame(1, 1'b0);
        drive_stream(10, 1'b0, cycles, first_acc, bad);
        rst = 1'b1;
        cyc();
        checks++; if (img_flat !== 128'd0 || flt_flat !== 72'd0) $display("FAIL midload_buses_cleared: got img=%h flt=%h want 0", img_flat, flt_flat); else passes++;
        checks++; if (bus.in_ready !== 1'b0 || array_rst !== 1'b1) $display("FAIL midload_ctrl: got ready=%b array_rst=%b want 0 1", bus.in_ready, array_rst); else passes++;
        rst = 1'b0;
        model_reset();
        cyc();
        queue_frame(0, 1'b1);
        n = tx_q.size();
        drive_stream(n, 1'b0, cycles, first_acc, bad);
        checks++; if (cycles !== n || bad !== 1'b0) $display("FAIL midload_reload: got cycles=%0d bad=%b want %0d 0", cycles, bad, n); else passes++;
        finish_window(fall, low, early, have, e);
        checks++; if (early !== 0 || fall !== 3 || low !== 50) $display("FAIL midload_window: got early=%0d fall=%0d low=%0d want 0 3 50", early, fall, low); else passes++;
        checks++; if (have !== 1'b1 || img_flat !== e.img || flt_flat !== e.flt || frame_count !== e.cnt) $display("FAIL midload_sb: got have=%b img=%h flt=%h cnt=%0d want img=%h flt=%h cnt=%0d", have, img_flat, flt_flat, frame_count, e.img, e.flt, e.cnt); else passes++;
    endtask

    task automatic test_reset_mid_compute();
        int cycles, n, waited, dones;
        bit first_acc, bad;
        queue_frame(0, 1'b0);
        n = tx_q.size();
        drive_stream(n, 1'b0, cycles, first_acc, bad);
        waited = 0;
        while (array_rst === 1'b1 && waited < 20) begin
            cyc();
            waited++;
        end
        checks++; if (array_rst !== 1'b0) $display("FAIL midcomp_window_open: got %b want 0", array_rst); else passes++;
        for (int i = 0; i < 19; i++) cyc();
        rst = 1'b1;
        cyc();
        checks++; if (array_rst !== 1'b1 || busy !== 1'b0) $display("FAIL midcomp_abort: got array_rst=%b busy=%b want 1 0", array_rst, busy); else passes++;
        checks++; if (frame_count !== 8'd0 || img_flat !== 128'd0) $display("FAIL midcomp_cleared: got cnt=%0d img=%h want 0 0", frame_count, img_flat); else passes++;
        rst = 1'b0;
        model_reset();
        dones = (frame_done === 1'b1) ? 1 : 0;
        for (int i = 0; i < 70; i++) begin
            cyc();
            if (frame_done === 1'b1) dones++;
        end
        checks++; if (dones !== 0) $display("FAIL midcomp_no_done: got %0d pulses want 0", dones); else passes++;
    endtask

    task automatic test_filter_reuse();
        int cycles, n, fall, low, early;
        bit first_acc, bad, have;
        exp_t e;
        queue_frame(0, 1'b1);
        n = tx_q.size();
        drive_stream(n, 1'b0, cycles, first_acc, bad);
        finish_window(fall, low, early, have, e);
        checks++; if (have !== 1'b1 || flt_flat !== e.flt) $display("FAIL reuse_first_frame: got have=%b flt=%h want %h", have, flt_flat, e.flt); else passes++;
        queue_frame(1, 1'b1);
        drive_stream(16, 1'b0, cycles, first_acc, bad);
`ifdef SYSTOLIC_LOADER_FILTER_REUSE_EN
        checks++; if (busy !== 1'b1 || bus.in_ready !== 1'b0 || tx_q.size() != 0) $display("FAIL reuse_hold_after_16: got busy=%b ready=%b left=%0d want 1 0 0", busy, bus.in_ready, tx_q.size()); else passes++;
        finish_window(fall, low, early, have, e);
        checks++; if (fall !== 3 || low !== 50) $display("FAIL reuse_window: got fall=%0d low=%0d want 3 50", fall, low); else passes++;
        checks++; if (flt_flat !== 72'h030200020001030101) $display("FAIL reuse_flt_kept: got %h want 030200020001030101", flt_flat); else passes++;
`else
        checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b1 || array_rst !== 1'b1) $display("FAIL noreuse_wait_flt: got busy=%b ready=%b array_rst=%b want 0 1 1", busy, bus.in_ready, array_rst); else passes++;
        for (int i = 0; i < 4; i++) cyc();
        checks++; if (busy !== 1'b0 || bus.in_ready !== 1'b1) $display("FAIL noreuse_still_waiting: got busy=%b ready=%b want 0 1", busy, bus.in_ready); else passes++;
        n = tx_q.size();
        drive_stream(n, 1'b0, cycles, first_acc, bad);
        checks++; if (cycles !== 9) $display("FAIL noreuse_flt_cycles: got %0d want 9", cycles); else passes++;
        finish_window(fall, low, early, have, e);
`endif
        checks++; if (have !== 1'b1 || img_flat !== e.img || flt_flat !== e.flt || frame_count !== e.cnt) $display("FAIL reuse_sb: got have=%b img=%h flt=%h cnt=%0d want img=%h flt=%h cnt=%0d", have, img_flat, flt_flat, frame_count, e.img, e.flt, e.cnt); else passes++;
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_throttled();
        test_back_to_back();
        test_reset_mid_load();
        test_reset_mid_compute();
        test_filter_reuse();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
        $fatal(1, "timeout");
    end
endmodule
